// File: rtl/wb_select_pipe.sv
// Writeback-source selector with a 2-entry elastic output queue.
// Picks one of NUM_SRC result buses, or the link address, at push time.
// Stores the selected value with its rd tag and write enable, and presents
// them to the register-file write port in strict FIFO order.
// The head entry lives in the output registers. A second "skid" entry holds
// the younger result while the head is stalled. Because the head lives in the
// output registers, the outputs keep their last values when the queue drains.
module wb_select_pipe #(
    parameter int DATA_W      = 32,
    parameter int NUM_SRC     = 4,
    parameter int SEL_W       = 3,
    parameter int LINK_SEL    = 7,
    parameter int LINK_OFFSET = 8,
    parameter int TAG_W       = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          src_sel,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [DATA_W-1:0]         pc_in,
    input  logic [TAG_W-1:0]          in_rd,
    input  logic                      in_we,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [TAG_W-1:0]          out_rd,
    output logic                      out_we,
    output logic                      sel_err
);

    logic              head_valid_q, head_valid_d;
    logic [DATA_W-1:0] head_data_q,  head_data_d;
    logic [TAG_W-1:0]  head_rd_q,    head_rd_d;
    logic              head_we_q,    head_we_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [TAG_W-1:0]  skid_rd_q,    skid_rd_d;
    logic              skid_we_q,    skid_we_d;
    logic              sel_err_q,    sel_err_d;

    logic              push, pop;
    logic              sel_ok;
    logic [DATA_W-1:0] new_data;
    logic              new_we;

    // The queue holds fewer than two entries exactly when the skid slot is empty.
    assign in_ready  = ~skid_valid_q & ~flush;
    assign push      = in_valid & in_ready;
    assign pop       = head_valid_q & out_ready;

    assign out_valid = head_valid_q;
    assign out_data  = head_data_q;
    assign out_rd    = head_rd_q;
    assign out_we    = head_we_q;
    assign sel_err   = sel_err_q;

    // Resolve the source select into the value and write enable to be stored.
    // An unknown code stores zero with the write enable cleared.
    always_comb begin
        new_data = '0;
        sel_ok   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_sel == SEL_W'(i)) begin
                new_data = src_data[i*DATA_W +: DATA_W];
                sel_ok   = 1'b1;
            end
        end
        if (src_sel == SEL_W'(LINK_SEL)) begin
            new_data = pc_in + DATA_W'(LINK_OFFSET);
            sel_ok   = 1'b1;
        end
        new_we = in_we & sel_ok;
    end

    // Next-state logic for the head/skid pair and the sticky error flag.
    always_comb begin
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        head_rd_d    = head_rd_q;
        head_we_d    = head_we_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_rd_d    = skid_rd_q;
        skid_we_d    = skid_we_q;
        sel_err_d    = sel_err_q | (push & ~sel_ok);

        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (pop) begin
                if (skid_valid_q) begin
                    head_data_d  = skid_data_q;
                    head_rd_d    = skid_rd_q;
                    head_we_d    = skid_we_q;
                    skid_valid_d = 1'b0;
                end else begin
                    head_valid_d = 1'b0;
                end
            end
            if (push) begin
                // A push while popping only happens with one entry queued,
                // so the new entry goes straight to the head.
                if (!head_valid_q || pop) begin
                    head_valid_d = 1'b1;
                    head_data_d  = new_data;
                    head_rd_d    = in_rd;
                    head_we_d    = new_we;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = new_data;
                    skid_rd_d    = in_rd;
                    skid_we_d    = new_we;
                end
            end
        end
    end

    // Queue and error-flag registers; reset empties everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
            head_rd_q    <= '0;
            head_we_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_rd_q    <= '0;
            skid_we_q    <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
            head_rd_q    <= head_rd_d;
            head_we_q    <= head_we_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_rd_q    <= skid_rd_d;
            skid_we_q    <= skid_we_d;
            sel_err_q    <= sel_err_d;
        end
    end

endmodule
